// File: rtl/spi_ram_responder.sv
`default_nettype none
// ============================================================================
// spi_ram_responder: SPI mode-0 byte-addressed serial SRAM model with preload
// Revision: 1.0
// ============================================================================
module spi_ram_responder #(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_READ   = 3'd3,
    S_WRITE  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic [6:0]             shift_q, shift_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   is_read_q, is_read_d;
  logic [7:0]             tx_q, tx_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [7:0]             mem_q [DEPTH];

  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [7:0]             mem_wdata;

  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, sck_rise, sck_fall;
  logic [7:0]             rx_byte;
  logic [ADDR_W-1:0]      addr_inc;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;
  assign rx_byte  = {shift_q, mosi_s};
  assign addr_inc = addr_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q[0]   <= spi_cs_n;
      sck_sync_q[0]  <= spi_sck;
      mosi_sync_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_q[i]   <= cs_sync_q[i-1];
        sck_sync_q[i]  <= sck_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      tx_q      <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      tx_q      <= tx_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    tx_d      = tx_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = rx_byte;

    if (state_q == S_IDLE) begin
      if (load_valid) begin
        mem_we    = 1'b1;
        mem_waddr = load_addr;
        mem_wdata = load_data;
      end
      if (cs_fall) begin
        state_d  = S_CMD;
        bitcnt_d = '0;
        shift_d  = '0;
      end
    end else if (cs_s) begin
      // Deselect wins over any coincident sck edge; a partial byte is dropped.
      state_d  = S_IDLE;
      bitcnt_d = '0;
      tx_d     = '0;
    end else begin
      case (state_q)
        S_CMD, S_ADDR, S_WRITE: begin
          if (sck_rise) begin
            shift_d = rx_byte[6:0];
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = '0;
              if (state_q == S_CMD) begin
                if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                  is_read_d = (rx_byte == CMD_READ);
                  state_d   = S_ADDR;
                end else begin
                  state_d   = S_IGNORE;
                  cmd_err_d = 1'b1;
                end
              end else if (state_q == S_ADDR) begin
                addr_d = rx_byte[ADDR_W-1:0];
                if (is_read_q) begin
                  state_d = S_READ;
                  tx_d    = mem_q[rx_byte[ADDR_W-1:0]];
                end else begin
                  state_d = S_WRITE;
                end
              end else begin
                mem_we = 1'b1;
                addr_d = addr_inc;
              end
            end else begin
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        S_READ: begin
          // bitcnt counts data rises; the fall trailing the address byte (count 0) must not shift.
          if (sck_rise && bitcnt_q != 4'd8) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (sck_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            addr_d   = addr_inc;
            tx_d     = mem_q[addr_inc];
          end else if (sck_fall && bitcnt_q != 4'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign spi_miso    = (state_q == S_READ) ? tx_q[7] : 1'b0;
  assign spi_miso_oe = (state_q == S_READ);
  assign busy        = (state_q != S_IDLE);
  assign load_ready  = (state_q == S_IDLE);
  assign cmd_err     = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_responder.sv
`default_nettype none
// ============================================================================
// tb_spi_ram_responder: directed self-checking bench for spi_ram_responder
// Revision: 1.0
// ============================================================================
module tb_spi_ram_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs_n, spi_sck, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       load_valid, load_ready;
  logic [7:0] load_addr, load_data;
  logic       busy, cmd_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  spi_ram_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_err === 1'b1) err_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic cs_start();
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    spi_cs_n = 1'b1;
    wait_clks(HALF + 4);
  endtask

  // Shift nbits of tx (MSB first); MISO sampled at the end of each low phase.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output logic oe_all, output logic oe_any);
    logic [7:0] t;
    t = tx; rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = t[7];
      t = {t[6:0], 1'b0};
      wait_clks(HALF);
      rx = {rx[6:0], spi_miso};
      oe_all = oe_all & spi_miso_oe;
      oe_any = oe_any | spi_miso_oe;
      spi_sck = 1'b1;
      wait_clks(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic read_bytes(input logic [7:0] a, input int n, output logic [7:0] d [4],
                            output logic oe_ok);
    logic [7:0] r;
    logic oa, oy;
    oe_ok = 1'b1;
    cs_start();
    xfer(8'h03, 8, r, oa, oy);
    xfer(a, 8, r, oa, oy);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, d[k], oa, oy);
      oe_ok = oe_ok & oa;
    end
    cs_end();
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    load_valid = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    wait_clks(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    rst = 1'b0;
    wait_clks(6);
  endtask

  task automatic test_read_stream();
    logic [7:0] d [4];
    logic ok;
    preload(8'h10, 8'hA5);
    preload(8'h11, 8'h3C);
    read_bytes(8'h10, 2, d, ok);
    checks++; if (d[0] !== 8'hA5) begin failures++; $display("FAIL read_b0 got=%h exp=a5", d[0]); end
    checks++; if (d[1] !== 8'h3C) begin failures++; $display("FAIL read_b1 got=%h exp=3c", d[1]); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL read_oe got=%b exp=1", ok); end
    checks++; if (spi_miso_oe !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL read_idle got oe=%b busy=%b exp 0 0", spi_miso_oe, busy); end
  endtask

  task automatic test_write_wrap();
    logic [7:0] r;
    logic [7:0] d [4];
    logic oa, oy, ok;
    cs_start();
    xfer(8'h02, 8, r, oa, oy);
    xfer(8'hFE, 8, r, oa, oy);
    xfer(8'h11, 8, r, oa, oy);
    xfer(8'h22, 8, r, oa, oy);
    xfer(8'h33, 8, r, oa, oy);
    checks++; if (oy !== 1'b0) begin failures++; $display("FAIL write_oe got=%b exp=0", oy); end
    cs_end();
    read_bytes(8'hFE, 3, d, ok);
    checks++; if (d[0] !== 8'h11) begin failures++; $display("FAIL wrap_fe got=%h exp=11", d[0]); end
    checks++; if (d[1] !== 8'h22) begin failures++; $display("FAIL wrap_ff got=%h exp=22", d[1]); end
    checks++; if (d[2] !== 8'h33) begin failures++; $display("FAIL wrap_00 got=%h exp=33", d[2]); end
  endtask

  task automatic test_partial_write();
    logic [7:0] r;
    logic [7:0] d [4];
    logic oa, oy, ok;
    cs_start();
    xfer(8'h02, 8, r, oa, oy);
    xfer(8'h40, 8, r, oa, oy);
    xfer(8'h77, 8, r, oa, oy);
    xfer(8'hF0, 4, r, oa, oy);
    cs_end();
    read_bytes(8'h40, 2, d, ok);
    checks++; if (d[0] !== 8'h77) begin failures++; $display("FAIL partial_40 got=%h exp=77", d[0]); end
    checks++; if (d[1] !== 8'h00) begin failures++; $display("FAIL partial_41 got=%h exp=00", d[1]); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] r, r2;
    logic [7:0] d [4];
    logic oa, oy, ok;
    err_cnt = 0;
    cs_start();
    xfer(8'h9F, 8, r, oa, oy);
    xfer(8'h02, 8, r2, oa, oy);
    xfer(8'h20, 8, r, oa, oy);
    r2 = r2 | r;
    xfer(8'h55, 8, r, oa, oy);
    r2 = r2 | r;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bad_busy got=%b exp=1", busy); end
    cs_end();
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL bad_err_pulse got=%0d cycles exp=1", err_cnt); end
    checks++; if (r2 !== 8'h00) begin failures++; $display("FAIL bad_miso got=%h exp=00", r2); end
    read_bytes(8'h20, 1, d, ok);
    checks++; if (d[0] !== 8'h00) begin failures++; $display("FAIL bad_nowrite got=%h exp=00", d[0]); end
    read_bytes(8'h10, 1, d, ok);
    checks++; if (d[0] !== 8'hA5) begin failures++; $display("FAIL bad_next_txn got=%h exp=a5", d[0]); end
  endtask

  task automatic test_load_blocked();
    logic [7:0] r;
    logic [7:0] d [4];
    logic oa, oy, ok;
    int cnt;
    cs_start();
    xfer(8'h03, 8, r, oa, oy);
    load_valid = 1'b1; load_addr = 8'h51; load_data = 8'hEE;
    wait_clks(4);
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL blk_ready got=%b exp=0", load_ready); end
    load_valid = 1'b0;
    xfer(8'h30, 4, r, oa, oy);
    load_valid = 1'b1; load_addr = 8'h50; load_data = 8'h99;
    wait_clks(2);
    spi_cs_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (load_ready !== 1'b1 && cnt < 50);
    @(negedge clk);
    load_valid = 1'b0;
    checks++; if (cnt !== 3) begin failures++; $display("FAIL blk_accept_lat got=%0d exp=3", cnt); end
    wait_clks(4);
    read_bytes(8'h50, 2, d, ok);
    checks++; if (d[0] !== 8'h99) begin failures++; $display("FAIL blk_accepted got=%h exp=99", d[0]); end
    checks++; if (d[1] !== 8'h00) begin failures++; $display("FAIL blk_nowrite got=%h exp=00", d[1]); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] r;
    logic [7:0] d [4];
    logic oa, oy, ok;
    cs_start();
    xfer(8'h03, 8, r, oa, oy);
    xfer(8'h10, 8, r, oa, oy);
    xfer(8'h00, 3, r, oa, oy);
    checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL rst_pre_oe got=%b exp=1", spi_miso_oe); end
    rst = 1'b1; spi_cs_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
      failures++; $display("FAIL rst_mid got busy=%b oe=%b miso=%b exp 0 0 0", busy, spi_miso_oe, spi_miso); end
    rst = 1'b0;
    wait_clks(6);
    read_bytes(8'h10, 2, d, ok);
    checks++; if (d[0] !== 8'h00 || d[1] !== 8'h00) begin
      failures++; $display("FAIL rst_mem_clear got=%h %h exp=00 00", d[0], d[1]); end
  endtask

  initial begin
    test_reset();
    test_read_stream();
    test_write_wrap();
    test_partial_write();
    test_bad_cmd();
    test_load_blocked();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
SPI mode-0 responder that models a byte-addressed serial SRAM on the far end of the CPU's cs_n/sck/mosi/miso link. It decodes READ (0x03) and WRITE (0x02) transactions with a one-byte address, auto-increments the address within a transaction, and serves or stores data bytes. SPI pins are oversampled in the clk domain, so the block can sit in the cocotb/board-level bench or on-chip as a loopback memory. A side-band preload port fills memory before the CPU runs.

Parameters:
ADDR_W, 8, address bits used from the address byte; depth = 2**ADDR_W bytes, upper address-byte bits ignored
SYNC_STAGES, 2, flip-flop stages on spi_cs_n, spi_sck and spi_mosi before edge detection

Ports:
clk  input  1  system clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
spi_cs_n  input  1  chip select from initiator, active low
spi_sck  input  1  SPI clock, mode 0 (idle low)
spi_mosi  input  1  serial data from initiator, MSB first
spi_miso  output  1  serial data to initiator, MSB first
spi_miso_oe  output  1  high while a READ data phase is in progress
load_valid  input  1  preload request
load_ready  output  1  preload accepted when load_valid & load_ready
load_addr  input  ADDR_W  preload address
load_data  input  8  preload byte
busy  output  1  high whenever state != IDLE
cmd_err  output  1  one-cycle pulse on an unrecognised command byte

Behaviour:
- Reset (sync, rst=1): state IDLE; spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0, load_ready=1; synchronisers, shift register, bit counter, address cleared to 0; all memory bytes cleared to 0x00.
- Synchronised cs_n/sck/mosi; rise/fall strobes are one clk wide from the last two synced sck samples. SCK high and low phases must each be >= SYNC_STAGES+2 clk cycles.
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- IDLE: synced cs_n falls -> CMD, bit counter=0.
- Any state: synced cs_n high -> IDLE next clk. cs_n high takes priority over a simultaneous sck edge, and that edge is discarded.
- CMD/ADDR/WRITE: shift mosi into the shift register on each sck rise, MSB first. On the 8th rise:
  - CMD: 0x03 or 0x02 -> ADDR, latching the command. Any other byte -> IGNORE and a cmd_err pulse in the same clk.
  - ADDR: address = byte[ADDR_W-1:0]. Latched command READ -> READ, with mem[address] loaded into the tx shift register and spi_miso_oe=1. Latched command WRITE -> WRITE.
  - WRITE: mem[address] <= byte; address increments, wrapping 2**ADDR_W-1 -> 0.
- READ:
  - spi_miso shows tx[7] immediately on entry, i.e. before the first data rise.
  - Each sck fall shifts tx left and drives the next bit.
  - On the fall after the 8th data rise, tx reloads from mem[address+1] with the address increment and wrap applied; reads stream indefinitely.
- IGNORE: all sck edges ignored; spi_miso=0; stays until cs_n high.
- cs_n high mid-byte: a partial WRITE byte is discarded and memory is unchanged. spi_miso and spi_miso_oe drop to 0 on the IDLE transition.
- Preload: load_ready=1 only in IDLE. A handshake writes mem[load_addr]=load_data that clk. If cs_n falls in the same clk, the preload still completes and CMD is entered the next clk.
- Reset mid-transaction: immediate return to the reset values listed above; the transaction is abandoned.

Test Plan:
- Preload 0xA5@0x10, 0x3C@0x11; SPI 0x03,0x10, then 16 data clocks -> MISO returns 0xA5 then 0x3C, with spi_miso_oe high throughout the data phase.
- SPI 0x02,0xFE then data 0x11,0x22,0x33; then read 3 bytes from 0xFE -> 0x11,0x22,0x33 (0xFF -> 0x00 wrap checked).
- WRITE 0x02,0x40, then 0x77 plus 4 bits, then cs_n high; read 0x40,0x41 -> 0x77, 0x00 (partial byte dropped).
- Command 0x9F -> cmd_err single-cycle pulse after the 8th rise, MISO stays 0, no memory change; the next transaction works normally.
- load_valid held during an active transaction -> load_ready=0, no write; accepted in the first IDLE clk after cs_n rises.
- rst=1 during READ data bit 3 -> next clk: busy=0, spi_miso_oe=0, memory reads back 0x00 at previously preloaded addresses.
